seg_display_arbiter: RTL and testbench

//  Shares the single 4-digit, common-anode seven-segment display between NUM_REQ requesters.

---
 rtl/seg_display_arbiter_pkg.sv | 34 +++
 rtl/seg_display_arbiter_if.sv | 23 ++
 rtl/seg_hex_decode.sv | 32 +++
 rtl/seg_display_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 137 +++++++++++++
 5 files changed

// File: rtl/seg_display_arbiter_pkg.sv
// Shared constants for the seven-segment display arbiter: active-low segment
// patterns, digit count and FSM state encoding.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [7:0]            SEG_BLANK = 8'hFF;
    localparam logic [NUM_DIGITS-1:0] SEL_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        SWITCH = 2'd2
    } state_e;

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Requester-side bundle of the display arbiter: requests, values, decimal
// points in; grant, busy and the active-low display pins out.
interface seg_display_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*16-1:0] data;
    logic [NUM_REQ*4-1:0]  dp;
    logic [NUM_REQ-1:0]    grant;
    logic                  busy;
    logic [3:0]            io_sel;
    logic [7:0]            io_seg;

    modport master (
        output req, data, dp,
        input  grant, busy, io_sel, io_seg
    );

    modport slave (
        input  req, data, dp,
        output grant, busy, io_sel, io_seg
    );
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_8;
        case (nibble)
            4'h0: seg_n = SEG_0;
            4'h1: seg_n = SEG_1;
            4'h2: seg_n = SEG_2;
            4'h3: seg_n = SEG_3;
            4'h4: seg_n = SEG_4;
            4'h5: seg_n = SEG_5;
            4'h6: seg_n = SEG_6;
            4'h7: seg_n = SEG_7;
            4'h8: seg_n = SEG_8;
            4'h9: seg_n = SEG_9;
            4'hA: seg_n = SEG_A;
            4'hB: seg_n = SEG_B;
            4'hC: seg_n = SEG_C;
            4'hD: seg_n = SEG_D;
            4'hE: seg_n = SEG_E;
            4'hF: seg_n = SEG_F;
            default: seg_n = SEG_8;
        endcase
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of a shared 4-digit common-anode display with minimum
// dwell, frame-buffered digit scanning and registered active-low pins.
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int SCAN_W       = 16,
    parameter int DWELL_FRAMES = 64
) (
    input logic                  clk,
    input logic                  rst,
    seg_display_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW_W  = $clog2(DWELL_FRAMES + 1);

    state_e              state_q, state_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [1:0]          digit_q, digit_d;
    logic [DW_W-1:0]     dwell_q, dwell_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [3:0]          io_sel_q, io_sel_d;
    logic [7:0]          io_seg_q, io_seg_d;
    logic [15:0]         buf_data_q, buf_data_d;
    logic [3:0]          buf_dp_q, buf_dp_d;

    logic                tick;
    logic                arb_found;
    logic [PTR_W-1:0]    arb_idx;
    logic [NUM_REQ-1:0]  owner_onehot;
    logic                other_req;
    logic [3:0]          nibble;
    logic                dp_bit;
    logic [6:0]          hex_seg_n;

    // Lowest index at or after ptr with a live request, wrapping mod NUM_REQ.
    function automatic logic [PTR_W:0] arbitrate(input logic [NUM_REQ-1:0] r,
                                                 input logic [PTR_W-1:0]   ptr);
        logic             found;
        logic [PTR_W-1:0] idx;
        int               j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!found && r[j]) begin
                found = 1'b1;
                idx   = PTR_W'(j);
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [15:0] pick_data(input logic [NUM_REQ*16-1:0] d,
                                              input logic [PTR_W-1:0]     idx);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (PTR_W'(i) == idx) r = d[i*16 +: 16];
        return r;
    endfunction

    function automatic logic [3:0] pick_dp(input logic [NUM_REQ*4-1:0] d,
                                           input logic [PTR_W-1:0]    idx);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (PTR_W'(i) == idx) r = d[i*4 +: 4];
        return r;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (PTR_W'(i) == idx) r[i] = 1'b1;
        return r;
    endfunction

    assign tick                 = &scan_cnt_q;
    assign {arb_found, arb_idx} = arbitrate(bus.req, rr_ptr_q);
    assign owner_onehot         = onehot(owner_q);
    assign other_req            = |(bus.req & ~owner_onehot);

    always_comb begin
        nibble = buf_data_q[15:12];
        dp_bit = buf_dp_q[3];
        case (digit_q)
            2'd1:    begin nibble = buf_data_q[11:8]; dp_bit = buf_dp_q[2]; end
            2'd2:    begin nibble = buf_data_q[7:4];  dp_bit = buf_dp_q[1]; end
            2'd3:    begin nibble = buf_data_q[3:0];  dp_bit = buf_dp_q[0]; end
            default: begin nibble = buf_data_q[15:12]; dp_bit = buf_dp_q[3]; end
        endcase
    end

    seg_hex_decode u_hex (
        .nibble (nibble),
        .seg_n  (hex_seg_n)
    );

    always_comb begin
        state_d    = state_q;
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        digit_d    = digit_q;
        dwell_d    = dwell_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        io_sel_d   = io_sel_q;
        io_seg_d   = io_seg_q;
        buf_data_d = buf_data_q;
        buf_dp_d   = buf_dp_q;

        case (state_q)
            IDLE: begin
                io_sel_d = SEL_BLANK;
                io_seg_d = SEG_BLANK;
                grant_d  = '0;
                if (arb_found) begin
                    state_d    = SHOW;
                    owner_d    = arb_idx;
                    grant_d    = onehot(arb_idx);
                    dwell_d    = '0;
                    digit_d    = '0;
                    buf_data_d = pick_data(bus.data, arb_idx);
                    buf_dp_d   = pick_dp(bus.dp, arb_idx);
                end
            end

            SHOW: begin
                // Owner drop wins over dwell expiry; both blank and hand over the same way.
                if (!bus.req[owner_q] ||
                    (tick && digit_q == 2'd0 && dwell_q == DW_W'(DWELL_FRAMES) && other_req)) begin
                    state_d  = SWITCH;
                    grant_d  = '0;
                    io_sel_d = SEL_BLANK;
                    io_seg_d = SEG_BLANK;
                    rr_ptr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
                end else if (tick) begin
                    io_sel_d = ~(4'b1000 >> digit_d);
                    io_seg_d = {~dp_bit, hex_seg_n};
                    digit_d  = digit_q + 2'd1;
                    if (digit_q == 2'd3) begin
                        if (dwell_q != DW_W'(DWELL_FRAMES)) dwell_d = dwell_q + DW_W'(1);
                        buf_data_d = pick_data(bus.data, owner_q);
                        buf_dp_d   = pick_dp(bus.dp, owner_q);
                    end
                end
            end

            SWITCH: begin
                if (tick) begin
                    if (arb_found) begin
                        state_d    = SHOW;
                        owner_d    = arb_idx;
                        grant_d    = onehot(arb_idx);
                        dwell_d    = '0;
                        digit_d    = '0;
                        buf_data_d = pick_data(bus.data, arb_idx);
                        buf_dp_d   = pick_dp(bus.dp, arb_idx);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                io_sel_d = SEL_BLANK;
                io_seg_d = SEG_BLANK;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            scan_cnt_q <= '0;
            digit_q    <= '0;
            dwell_q    <= '0;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            io_sel_q   <= SEL_BLANK;
            io_seg_q   <= SEG_BLANK;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            dwell_q    <= dwell_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            io_sel_q   <= io_sel_d;
            io_seg_q   <= io_seg_d;
        end
        buf_data_q <= buf_data_d;
        buf_dp_q   <= buf_dp_d;
    end

    assign bus.grant  = grant_q;
    assign bus.busy   = busy_q;
    assign bus.io_sel = io_sel_q;
    assign bus.io_seg = io_seg_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with NUM_REQ=2, SCAN_W=2 (tick every
// 4 clk) and DWELL_FRAMES=2; edge numbers below count posedges since reset release.
module tb_seg_display_arbiter;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    seg_display_arbiter_if #(.NUM_REQ(2)) bus ();

    seg_display_arbiter #(
        .NUM_REQ      (2),
        .SCAN_W       (2),
        .DWELL_FRAMES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_io(input string tag, input logic [3:0] sel, input logic [7:0] seg);
        check({tag, ".sel"}, {12'h0, bus.io_sel}, {12'h0, sel});
        check({tag, ".seg"}, {8'h0, bus.io_seg}, {8'h0, seg});
    endtask

    task automatic check_ctl(input string tag, input logic [1:0] gnt, input logic bsy);
        check({tag, ".grant"}, {14'h0, bus.grant}, {14'h0, gnt});
        check({tag, ".busy"}, {15'h0, bus.busy}, {15'h0, bsy});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.req      = 2'b00;
        bus.data     = {16'hBEEF, 16'hDEAD};
        bus.dp       = 8'h00;

        // Reset held for 3 clocks, then idle with no requests.
        step(3);
        check_io("rst_io", 4'hF, 8'hFF);
        check_ctl("rst_ctl", 2'b00, 1'b0);
        rst = 1'b0;
        step(4);
        check_io("idle_io", 4'hF, 8'hFF);
        check_ctl("idle_ctl", 2'b00, 1'b0);

        // Requester 0 alone: granted one clock later, DEAD scanned left to right.
        bus.req = 2'b01;
        step(1);                                   // edge 5
        check_ctl("grant0", 2'b01, 1'b1);
        check_io("grant0_blank", 4'hF, 8'hFF);
        step(3);  check_io("dead_d0", 4'h7, 8'hA1); // edge 8
        bus.req = 2'b11;
        step(4);  check_io("dead_d1", 4'hB, 8'h86); // edge 12
        step(4);  check_io("dead_d2", 4'hD, 8'h88); // edge 16
        step(4);  check_io("dead_d3", 4'hE, 8'hA1); // edge 20
        step(4);  check_io("dead_f2_d0", 4'h7, 8'hA1);
        step(12); check_io("dead_f2_d3", 4'hE, 8'hA1); // edge 36
        check_ctl("dead_f2_ctl", 2'b01, 1'b1);

        // Dwell expired with requester 1 waiting: blank tick, then BEEF.
        step(4);                                   // edge 40
        check_io("sw01_blank", 4'hF, 8'hFF);
        check_ctl("sw01_ctl", 2'b00, 1'b1);
        step(4);                                   // edge 44
        check_ctl("grant1", 2'b10, 1'b1);
        check_io("grant1_blank", 4'hF, 8'hFF);
        step(4); check_io("beef_d0", 4'h7, 8'h83);
        step(4); check_io("beef_d1", 4'hB, 8'h86);
        step(4); check_io("beef_d2", 4'hD, 8'h86);
        step(4); check_io("beef_d3", 4'hE, 8'h8E); // edge 60
        step(20);                                  // edge 80
        check_ctl("sw10_ctl", 2'b00, 1'b1);
        check_io("sw10_blank", 4'hF, 8'hFF);
        step(4);                                   // edge 84
        check_ctl("regrant0", 2'b01, 1'b1);

        // Data change mid-frame appears only from the following frame.
        step(4); check_io("mid_d0", 4'h7, 8'hA1);  // edge 88
        step(4); check_io("mid_d1", 4'hB, 8'h86);  // edge 92
        bus.data = {16'hBEEF, 16'h1234};
        bus.dp   = 8'h01;
        step(4); check_io("mid_d2", 4'hD, 8'h88);
        step(4); check_io("mid_d3", 4'hE, 8'hA1);  // edge 100
        step(4); check_io("new_d0", 4'h7, 8'hF9);
        step(4); check_io("new_d1", 4'hB, 8'hA4);
        step(4); check_io("new_d2", 4'hD, 8'hB0);
        step(4); check_io("new_d3_dp", 4'hE, 8'h19); // edge 116
        step(4); check_ctl("sw2_ctl", 2'b00, 1'b1);  // edge 120
        step(4); check_ctl("grant1_again", 2'b10, 1'b1); // edge 124, rr_ptr now 1

        // Reset pulse while requester 1 owns the display.
        step(6);                                   // edge 130
        rst = 1'b1;
        step(1);
        check_io("midrst_io", 4'hF, 8'hFF);
        check_ctl("midrst_ctl", 2'b00, 1'b0);
        rst = 1'b0;
        step(1);                                   // m=1
        check_ctl("post_rst_grant", 2'b01, 1'b1);
        step(3);                                   // m=4
        check_io("post_rst_d0", 4'h7, 8'hF9);

        // Owner drops mid-frame with nobody else waiting.
        bus.req = 2'b00;
        step(1);                                   // m=5
        check_ctl("drop_ctl", 2'b00, 1'b1);
        check_io("drop_blank", 4'hF, 8'hFF);
        step(2);                                   // m=7, still in SWITCH
        check_ctl("drop_hold", 2'b00, 1'b1);
        step(1);                                   // m=8, tick ends SWITCH
        check_ctl("drop_idle", 2'b00, 1'b0);
        check_io("drop_idle_io", 4'hF, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
